// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [7:0] OFS_DIG_LO = 8'd0;
  localparam logic [7:0] OFS_DIG_HI = 8'd1;
  localparam logic [7:0] OFS_CTRL   = 8'd2;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] SEL_OFF = 4'hF;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_BLANK,
    ST_SHOW
  } state_e;

  // Active-low g..a patterns, entry 15 first.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] d;
    logic                       lzb;
    logic [NUM_DIGITS-1:0]      dp;
  } disp_regs_t;

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Processor write bus into the scan controller.
interface seven_seg_scan_ctrl_if;
  logic [7:0] addr;
  logic [7:0] data;
  logic       we;

  modport master (output addr, output data, output we);
  modport slave  (input addr, input data, input we);
endinterface

// File: rtl/seven_seg_scan_ctrl_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[nib];
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment driver with frame-synchronous
// (tear-free) register commit and leading-zero blanking.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR    = 8'hD0,
  parameter int         DWELL_CYCLES = 2500,
  parameter int         BLANK_CYCLES = 25,
  parameter int         CNT_WIDTH    = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  seven_seg_scan_ctrl_if.slave   bus,
  output logic [3:0]             sel,
  output logic [7:0]             digit,
  output logic                   frame_done
);

  localparam logic [CNT_WIDTH-1:0] DWELL_LAST = CNT_WIDTH'(DWELL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] BLANK_LAST = CNT_WIDTH'(BLANK_CYCLES - 1);

  disp_regs_t shadow, active;
  logic       en;

  state_e               state, state_nxt;
  logic [1:0]           idx, idx_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 frame_end;

  logic [3:0] sel_nxt;
  logic [7:0] digit_nxt;

  logic wr_lo, wr_hi, wr_ctrl;
  assign wr_lo   = bus.we && (bus.addr == BASE_ADDR + OFS_DIG_LO);
  assign wr_hi   = bus.we && (bus.addr == BASE_ADDR + OFS_DIG_HI);
  assign wr_ctrl = bus.we && (bus.addr == BASE_ADDR + OFS_CTRL);

  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^bus.data[3:2];

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    frame_end = 1'b0;
    unique case (state)
      ST_OFF: begin
        idx_nxt = '0;
        cnt_nxt = '0;
        if (en) state_nxt = ST_BLANK;
      end
      ST_BLANK: begin
        if (!en) begin
          state_nxt = ST_OFF;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end else if (cnt == BLANK_LAST) begin
          state_nxt = ST_SHOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      ST_SHOW: begin
        if (!en) begin
          state_nxt = ST_OFF;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end else if (cnt == DWELL_LAST) begin
          state_nxt = ST_BLANK;
          cnt_nxt   = '0;
          idx_nxt   = idx + 2'd1;
          frame_end = (idx == 2'd3);
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = ST_OFF;
        idx_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  logic [NUM_DIGITS-1:0][6:0] seg;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    hex_to_seg_decoder u_dec (.nib(active.d[i]), .seg(seg[i]));
  end

  // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
  logic [NUM_DIGITS-1:0] suppress;
  logic                  zero_run;
  always_comb begin
    suppress = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run && (active.d[i] == 4'd0);
      suppress[i] = active.lzb && zero_run;
    end
  end

  // Outputs follow the next state so they change on the state-entry edge.
  // Active registers never change on an edge that enters SHOW.
  always_comb begin
    sel_nxt   = SEL_OFF;
    digit_nxt = SEG_OFF;
    if (state_nxt == ST_SHOW && !suppress[idx_nxt]) begin
      sel_nxt   = ~(4'b0001 << idx_nxt);
      digit_nxt = {~active.dp[idx_nxt], seg[idx_nxt]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_OFF;
      idx        <= '0;
      cnt        <= '0;
      sel        <= SEL_OFF;
      digit      <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      sel        <= sel_nxt;
      digit      <= digit_nxt;
      frame_done <= frame_end;
    end
  end

  // Commit samples the pre-write shadow, so a write on the commit edge waits a frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      en     <= 1'b0;
      shadow <= '0;
      active <= '0;
    end else begin
      if (state == ST_OFF || frame_end) active <= shadow;
      if (wr_lo) shadow.d[1:0] <= bus.data;
      if (wr_hi) shadow.d[3:2] <= bus.data;
      if (wr_ctrl) begin
        en         <= bus.data[0];
        shadow.lzb <= bus.data[1];
        shadow.dp  <= bus.data[7:4];
      end
    end
  end

endmodule
